i_cache_nway: RTL and testbench

I_CACHE_NWAY -- requirements
Module: i_cache_nway

---
 rtl/i_cache_pkg.sv | 19 +
 rtl/i_cache_way_ram.sv | 68 ++++++
 rtl/i_cache_nway.sv | 243 ++++++++++++++++++++++++
 tb/tb_i_cache_nway.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_cache_pkg.sv
// Shared definitions for the n-way instruction cache.
// Holds the parameter defaults used by i_cache_nway and the FSM state
// encodings. States are plain localparam constants so that existing code
// comparing against 3-bit literals keeps working.
package i_cache_pkg;

    localparam int WAYS_DEF   = 2;
    localparam int SETS_DEF   = 64;
    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 32;
    localparam int AGE_W_DEF  = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_REFILL = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

endpackage

// File: rtl/i_cache_way_ram.sv
// One way of the instruction cache: tag, valid and data per set.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset (valid bits only)
//   rd_en, rd_idx            synchronous read request; result next cycle on
//   rd_valid, rd_tag, rd_data
//   wr_en, wr_idx, wr_tag,   line fill: marks the set valid and stores tag/data
//   wr_data
//   clr_en, clr_idx          flush port: invalidates one set
module i_cache_way_ram
    import i_cache_pkg::*;
#(
    parameter int SETS   = SETS_DEF,
    parameter int TAG_W  = 32,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [$clog2(SETS)-1:0]  rd_idx,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(SETS)-1:0]  wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_en,
    input  logic [$clog2(SETS)-1:0]  clr_idx
);

    logic [SETS-1:0]   valid_mem;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [DATA_W-1:0] data_mem [SETS];

    // Valid bits are the only state that must come out of reset cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_mem <= '0;
        end else if (clr_en) begin
            valid_mem[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid_mem[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= valid_mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_idx];
            rd_data <= data_mem[rd_idx];
        end
    end

endmodule

// File: rtl/i_cache_nway.sv
// N-way set-associative instruction cache, one instruction per line.
// A fetch is accepted in IDLE, looked up one cycle later, and on a miss a
// single-word refill is requested from memory. Replacement uses per-way age
// counters (age 0 = most recently used). fence_i invalidates the whole cache
// one set per cycle once any in-flight fetch has completed.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   inst_req, inst_addr    fetch request / address (held until inst_valid)
//   fence_i                pulse: invalidate all lines
//   inst_valid, inst_data  one-cycle response; data is 0 when not valid
//   busy                   high whenever the FSM is not idle
//   mem_req, mem_addr      refill request and word-aligned address
//   mem_data, mem_ok       refill data and its one-cycle completion strobe
module i_cache_nway
    import i_cache_pkg::*;
#(
    parameter int WAYS   = WAYS_DEF,
    parameter int SETS   = SETS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AGE_W  = AGE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              fence_i,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ok
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

    logic [2:0]        state;
    logic              fence_pend;
    logic [IDX_W-1:0]  flush_idx;
    logic [WAY_W-1:0]  victim_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] resp_data;
    logic [AGE_W-1:0]  age_mem [SETS][WAYS];

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic              unused_addr_lsb;

    assign req_idx         = inst_addr[IDX_W+1:2];
    assign cur_idx         = addr_q[IDX_W+1:2];
    assign cur_tag         = addr_q[ADDR_W-1:IDX_W+2];
    assign unused_addr_lsb = ^addr_q[1:0];

    logic rd_en;
    logic fill_en;
    logic flush_en;

    assign rd_en    = (state == S_IDLE) && !fence_pend && inst_req;
    assign fill_en  = (state == S_REFILL) && mem_ok;
    assign flush_en = (state == S_FLUSH);

    logic [WAYS-1:0]   rd_valid;
    logic [TAG_W-1:0]  rd_tag  [WAYS];
    logic [DATA_W-1:0] rd_data [WAYS];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        i_cache_way_ram #(
            .SETS   (SETS),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_ram (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en),
            .rd_idx   (req_idx),
            .rd_valid (rd_valid[w]),
            .rd_tag   (rd_tag[w]),
            .rd_data  (rd_data[w]),
            .wr_en    (fill_en && (victim_q == WAY_W'(w))),
            .wr_idx   (cur_idx),
            .wr_tag   (cur_tag),
            .wr_data  (mem_data),
            .clr_en   (flush_en),
            .clr_idx  (flush_idx)
        );
    end

    // Hit detection: scan downwards so the lowest-indexed matching way wins.
    logic             hit;
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && (rd_tag[w] == cur_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: first invalid way, else oldest way (strict > keeps ties low).
    logic             victim_found;
    logic [AGE_W-1:0] victim_age;
    logic [WAY_W-1:0] victim;

    always_comb begin
        victim_found = 1'b0;
        victim       = '0;
        victim_age   = age_mem[cur_idx][0];
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !rd_valid[w]) begin
                victim_found = 1'b1;
                victim       = WAY_W'(w);
            end
        end
        if (!victim_found) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age_mem[cur_idx][w] > victim_age) begin
                    victim_age = age_mem[cur_idx][w];
                    victim     = WAY_W'(w);
                end
            end
        end
    end

    logic             age_upd;
    logic [WAY_W-1:0] acc_way;

    assign age_upd = ((state == S_LOOKUP) && hit) || fill_en;
    assign acc_way = (state == S_LOOKUP) ? hit_way : victim_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_mem[s][w] <= '0;
                end
            end
        end else if (flush_en) begin
            for (int w = 0; w < WAYS; w++) begin
                age_mem[flush_idx][w] <= '0;
            end
        end else if (age_upd) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == acc_way) begin
                    age_mem[cur_idx][w] <= '0;
                end else if (rd_valid[w]) begin
                    age_mem[cur_idx][w] <= age_sat_inc(age_mem[cur_idx][w]);
                end
            end
        end
    end

    // Control state. A fence arriving in the cycle the flush starts wins over
    // the clear, so it causes one further full flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            fence_pend <= 1'b0;
            flush_idx  <= '0;
            victim_q   <= '0;
        end else begin
            if (fence_i) begin
                fence_pend <= 1'b1;
            end else if (state == S_IDLE) begin
                fence_pend <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (fence_pend) begin
                        state     <= S_FLUSH;
                        flush_idx <= '0;
                    end else if (inst_req) begin
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        state <= S_IDLE;
                    end else begin
                        victim_q <= victim;
                        state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ok) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                S_FLUSH: begin
                    flush_idx <= flush_idx + 1'b1;
                    if (flush_idx == IDX_W'(SETS - 1)) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            addr_q <= inst_addr;
        end
        if (fill_en) begin
            resp_data <= mem_data;
        end
    end

    always_comb begin
        inst_valid = 1'b0;
        inst_data  = '0;
        if ((state == S_LOOKUP) && hit) begin
            inst_valid = 1'b1;
            inst_data  = rd_data[hit_way];
        end else if (state == S_RESP) begin
            inst_valid = 1'b1;
            inst_data  = resp_data;
        end
    end

    assign busy     = (state != S_IDLE);
    assign mem_req  = (state == S_REFILL);
    assign mem_addr = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_i_cache_nway.sv
`timescale 1ns/1ps
module tb_i_cache_nway;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req   [2];
    logic [63:0] addr  [2];
    logic        fence [2];
    logic        vld   [2];
    logic [31:0] dat   [2];
    logic        bsy   [2];
    logic        mreq  [2];
    logic [63:0] maddr [2];
    logic [31:0] mdata [2];
    logic        mok   [2];

    int errors = 0;
    int checks = 0;

    int m_valid [16][4];
    int m_tag   [16][4];
    int m_age   [16][4];

    always #5 clk = ~clk;

    i_cache_nway dut2 (
        .clk(clk), .rst(rst), .inst_req(req[0]), .inst_addr(addr[0]), .fence_i(fence[0]),
        .inst_valid(vld[0]), .inst_data(dat[0]), .busy(bsy[0]), .mem_req(mreq[0]),
        .mem_addr(maddr[0]), .mem_data(mdata[0]), .mem_ok(mok[0])
    );

    i_cache_nway #(.WAYS(4), .SETS(16), .ADDR_W(64), .DATA_W(32), .AGE_W(3)) dut4 (
        .clk(clk), .rst(rst), .inst_req(req[1]), .inst_addr(addr[1]), .fence_i(fence[1]),
        .inst_valid(vld[1]), .inst_data(dat[1]), .busy(bsy[1]), .mem_req(mreq[1]),
        .mem_addr(maddr[1]), .mem_data(mdata[1]), .mem_ok(mok[1])
    );

    function automatic logic [31:0] memf(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Reference cache for the 4-way/16-set instance: returns 1 on hit and
    // applies the replacement and age rules for one access.
    function automatic bit model_access(input int s, input int t);
        int w;
        bit h;
        w = -1;
        for (int i = 0; i < 4; i++)
            if (w < 0 && m_valid[s][i] != 0 && m_tag[s][i] == t) w = i;
        h = (w >= 0);
        if (!h) begin
            for (int i = 0; i < 4; i++)
                if (w < 0 && m_valid[s][i] == 0) w = i;
            if (w < 0) begin
                w = 0;
                for (int i = 1; i < 4; i++)
                    if (m_age[s][i] > m_age[s][w]) w = i;
            end
            m_valid[s][w] = 1;
            m_tag[s][w]   = t;
        end
        for (int i = 0; i < 4; i++) begin
            if (i == w) m_age[s][i] = 0;
            else if (m_valid[s][i] != 0 && m_age[s][i] < 7) m_age[s][i] = m_age[s][i] + 1;
        end
        return h;
    endfunction

    // Drives one fetch from a negedge with the DUT idle and acts as memory.
    // Returns: mem_req cycles, mem_req transactions, cycles from acceptance
    // to inst_valid, returned data, completion flag, first mem_addr, and the
    // number of non-valid cycles where inst_data was nonzero.
    task automatic fetch(input int k, input logic [63:0] a, input int dly, input logic [31:0] rdata,
                         input int fence_at, output int ncyc, output int nreq, output int lat,
                         output logic [31:0] d, output bit got, output logic [63:0] ma, output int bad);
        bit prev;
        prev = 0; ncyc = 0; nreq = 0; lat = 0; d = '0; got = 0; ma = '0; bad = 0;
        req[k] = 1'b1;
        addr[k] = a;
        for (int cyc = 1; cyc <= 300 && !got; cyc++) begin
            @(negedge clk);
            mok[k] = 1'b0;
            fence[k] = (cyc == fence_at);
            if (vld[k]) begin
                got = 1; lat = cyc; d = dat[k]; req[k] = 1'b0;
            end else begin
                if (dat[k] !== '0) bad++;
                if (mreq[k]) begin
                    ncyc++;
                    if (!prev) begin
                        nreq++;
                        if (nreq == 1) ma = maddr[k];
                    end
                    if (ncyc == dly) begin
                        mok[k] = 1'b1; mdata[k] = rdata;
                    end
                end
            end
            prev = mreq[k];
        end
        req[k] = 1'b0; mok[k] = 1'b0; fence[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b1; addr[k] = '1; mok[k] = 1'b1; mdata[k] = '1; fence[k] = 1'b1;
        end
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (vld[k] !== 1'b0) begin errors++; $display("FAIL reset_inst_valid[%0d]: got %b want 0", k, vld[k]); end
            checks++; if (dat[k] !== '0) begin errors++; $display("FAIL reset_inst_data[%0d]: got %h want 0", k, dat[k]); end
            checks++; if (bsy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", k, bsy[k]); end
            checks++; if (mreq[k] !== 1'b0) begin errors++; $display("FAIL reset_mem_req[%0d]: got %b want 0", k, mreq[k]); end
            checks++; if (maddr[k] !== '0) begin errors++; $display("FAIL reset_mem_addr[%0d]: got %h want 0", k, maddr[k]); end
        end
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; addr[k] = '0; mok[k] = 1'b0; mdata[k] = '0; fence[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL reset_no_flush: busy %b want 0", bsy[0]); end
    endtask

    task automatic test_cold_miss();
        int nc, nr, lat, bad; logic [31:0] d; bit got; logic [63:0] ma;
        fetch(0, 64'h8000_0000, 3, 32'h0000_0413, 0, nc, nr, lat, d, got, ma, bad);
        checks++; if (!got) begin errors++; $display("FAIL cold_done: no inst_valid got 0 want 1"); end
        checks++; if (nc != 3) begin errors++; $display("FAIL cold_mem_req_cycles: got %0d want 3", nc); end
        checks++; if (lat != 5) begin errors++; $display("FAIL cold_latency: got %0d want 5", lat); end
        checks++; if (d !== 32'h0000_0413) begin errors++; $display("FAIL cold_data: got %h want 00000413", d); end
        checks++; if (ma !== 64'h8000_0000) begin errors++; $display("FAIL cold_mem_addr: got %h want 80000000", ma); end
        checks++; if (bad != 0) begin errors++; $display("FAIL cold_idle_data: got %0d nonzero cycles want 0", bad); end
    endtask

    task automatic test_hit();
        int nc, nr, lat, bad; logic [31:0] d; bit got; logic [63:0] ma;
        fetch(0, 64'h8000_0000, 2, 32'hDEAD_BEEF, 0, nc, nr, lat, d, got, ma, bad);
        checks++; if (nr != 0) begin errors++; $display("FAIL hit_no_mem_req: got %0d want 0", nr); end
        checks++; if (lat != 1) begin errors++; $display("FAIL hit_latency: got %0d want 1", lat); end
        checks++; if (d !== 32'h0000_0413) begin errors++; $display("FAIL hit_data: got %h want 00000413", d); end
    endtask

    task automatic test_stray_ok();
        mok[0] = 1'b1; mdata[0] = 32'h0BAD_0BAD;
        @(negedge clk);
        mok[0] = 1'b0;
        checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL stray_ok_valid: got %b want 0", vld[0]); end
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL stray_ok_busy: got %b want 0", bsy[0]); end
    endtask

    task automatic test_lru();
        logic [63:0] seq [6];
        bit          exp_hit [6];
        int nc, nr, lat, bad; logic [31:0] d; bit got; logic [63:0] ma;
        seq[0] = 64'h114; exp_hit[0] = 0;
        seq[1] = 64'h214; exp_hit[1] = 0;
        seq[2] = 64'h114; exp_hit[2] = 1;
        seq[3] = 64'h314; exp_hit[3] = 0;
        seq[4] = 64'h114; exp_hit[4] = 1;
        seq[5] = 64'h214; exp_hit[5] = 0;
        for (int i = 0; i < 6; i++) begin
            fetch(0, seq[i], 2, memf(seq[i]), 0, nc, nr, lat, d, got, ma, bad);
            checks++; if (nr != (exp_hit[i] ? 0 : 1)) begin errors++; $display("FAIL lru_step%0d_mem_req: got %0d want %0d", i, nr, exp_hit[i] ? 0 : 1); end
            checks++; if (d !== memf(seq[i])) begin errors++; $display("FAIL lru_step%0d_data: got %h want %h", i, d, memf(seq[i])); end
        end
    endtask

    task automatic test_fence_refill();
        int nc, nr, lat, bad, cnt; logic [31:0] d; bit got; logic [63:0] ma;
        fetch(0, 64'h1008, 4, memf(64'h1008), 3, nc, nr, lat, d, got, ma, bad);
        checks++; if (d !== memf(64'h1008)) begin errors++; $display("FAIL fence_refill_data: got %h want %h", d, memf(64'h1008)); end
        checks++; if (nc != 4) begin errors++; $display("FAIL fence_refill_req_cycles: got %0d want 4", nc); end
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bsy[0]) cnt++;
        end
        checks++; if (cnt != 64) begin errors++; $display("FAIL fence_flush_cycles: got %0d want 64", cnt); end
        fetch(0, 64'h8000_0000, 2, 32'h0000_0413, 0, nc, nr, lat, d, got, ma, bad);
        checks++; if (nr != 1) begin errors++; $display("FAIL fence_refetch_miss: got %0d want 1", nr); end
        checks++; if (d !== 32'h0000_0413) begin errors++; $display("FAIL fence_refetch_data: got %h want 00000413", d); end
        fetch(0, 64'h114, 1, memf(64'h114), 0, nc, nr, lat, d, got, ma, bad);
        checks++; if (nr != 1) begin errors++; $display("FAIL fence_other_set_miss: got %0d want 1", nr); end
    endtask

    task automatic test_double_fence();
        int cnt;
        cnt = 0;
        fence[0] = 1'b1;
        for (int i = 1; i <= 250; i++) begin
            @(negedge clk);
            fence[0] = (i == 20);
            if (bsy[0]) cnt++;
        end
        fence[0] = 1'b0;
        checks++; if (cnt != 128) begin errors++; $display("FAIL double_fence_cycles: got %0d want 128", cnt); end
    endtask

    task automatic test_reset_refill();
        int nc, nr, lat, bad, vcnt; logic [31:0] d; bit got; logic [63:0] ma;
        req[0] = 1'b1; addr[0] = 64'h2040;
        repeat (3) @(negedge clk);
        rst = 1'b0; req[0] = 1'b0;
        #1;
        checks++; if (mreq[0] !== 1'b0) begin errors++; $display("FAIL rst_refill_mem_req: got %b want 0", mreq[0]); end
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL rst_refill_busy: got %b want 0", bsy[0]); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mok[0] = 1'b1; mdata[0] = 32'hFACE_0001;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mok[0] = 1'b0;
            if (vld[0]) vcnt++;
        end
        checks++; if (vcnt != 0) begin errors++; $display("FAIL rst_late_ok_valid: got %0d pulses want 0", vcnt); end
        fetch(0, 64'h2040, 2, memf(64'h2040), 0, nc, nr, lat, d, got, ma, bad);
        checks++; if (nr != 1) begin errors++; $display("FAIL rst_next_fetch_miss: got %0d want 1", nr); end
        checks++; if (d !== memf(64'h2040)) begin errors++; $display("FAIL rst_next_fetch_data: got %h want %h", d, memf(64'h2040)); end
    endtask

    task automatic test_sweep();
        int nc, nr, lat, bad, s, t, dly; logic [31:0] d; bit got, h; logic [63:0] ma, a;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++) begin m_valid[i][j] = 0; m_tag[i][j] = 0; m_age[i][j] = 0; end
        for (int n = 0; n < 1000; n++) begin
            if (n % 100 == 99) begin
                fence[1] = 1'b1;
                @(negedge clk);
                fence[1] = 1'b0;
                repeat (20) @(negedge clk);
                checks++; if (bsy[1] !== 1'b0) begin errors++; $display("FAIL sweep_fence_idle n=%0d: busy %b want 0", n, bsy[1]); end
                for (int i = 0; i < 16; i++)
                    for (int j = 0; j < 4; j++) begin m_valid[i][j] = 0; m_age[i][j] = 0; end
            end
            s = $urandom_range(15);
            t = $urandom_range(5);
            a = (64'(t) << 6) | (64'(s) << 2) | 64'($urandom_range(3));
            dly = $urandom_range(1, 4);
            h = model_access(s, t);
            fetch(1, a, dly, memf(a), 0, nc, nr, lat, d, got, ma, bad);
            checks++; if (d !== memf(a)) begin errors++; $display("FAIL sweep_data n=%0d addr=%h: got %h want %h", n, a, d, memf(a)); end
            checks++; if (nr != (h ? 0 : 1)) begin errors++; $display("FAIL sweep_mem_req n=%0d addr=%h: got %0d want %0d", n, a, nr, h ? 0 : 1); end
            checks++; if (lat != (h ? 1 : dly + 2)) begin errors++; $display("FAIL sweep_latency n=%0d: got %0d want %0d", n, lat, h ? 1 : dly + 2); end
            if (!h) begin
                checks++; if (ma !== {a[63:2], 2'b00}) begin errors++; $display("FAIL sweep_mem_addr n=%0d: got %h want %h", n, ma, {a[63:2], 2'b00}); end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; addr[k] = '0; fence[k] = 1'b0; mdata[k] = '0; mok[k] = 1'b0;
        end
        test_reset();
        test_cold_miss();
        test_hit();
        test_stray_ok();
        test_lru();
        test_fence_refill();
        test_double_fence();
        test_reset_refill();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
